// File: rtl/parking_pkg.sv
// Shared types, 7-segment glyphs and BCD helpers for the parking-lot occupancy block.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3,
    WAIT_CLR
  } lane_state_t;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Double-dabble into eight BCD digits; digits above the display width are ignored by callers.
  function automatic logic [31:0] bin2bcd(input logic [31:0] bin);
    logic [31:0] bcd;
    bcd = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int d = 0; d < 8; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[30:0], bin[i]};
    end
    return bcd;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/parking_lot_counter_lane.sv
// One entry/exit lane: synchronises and debounces the sensor pair, then tracks the
// vehicle direction and emits a single-cycle pulse per completed pass.
module lane_fsm
  import parking_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic btnC,
  input  logic s1_raw,
  input  logic s2_raw,
  output logic enter_pulse,
  output logic exit_pulse
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  // Bit 1 carries S1 (outer), bit 0 carries S2 (inner).
  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    filt;
  logic [DW-1:0] db_cnt [2];
  lane_state_t   state;

  always_ff @(posedge clk) begin
    if (btnC) begin
      meta      <= '0;
      sync      <= '0;
      filt      <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      meta <= {s1_raw, s2_raw};
      sync <= meta;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
          filt[i]   <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      state       <= IDLE;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      case (state)
        IDLE:
          case (filt)
            2'b10:   state <= EN1;
            2'b01:   state <= EX1;
            2'b11:   state <= WAIT_CLR;
            default: state <= IDLE;
          endcase
        EN1:
          case (filt)
            2'b11:   state <= EN2;
            2'b00:   state <= IDLE;
            2'b01:   state <= WAIT_CLR;
            default: state <= EN1;
          endcase
        EN2:
          case (filt)
            2'b01:   state <= EN3;
            2'b10:   state <= EN1;
            2'b00:   state <= IDLE;
            default: state <= EN2;
          endcase
        EN3:
          case (filt)
            2'b00: begin
              state       <= IDLE;
              enter_pulse <= 1'b1;
            end
            2'b11:   state <= EN2;
            2'b10:   state <= WAIT_CLR;
            default: state <= EN3;
          endcase
        EX1:
          case (filt)
            2'b11:   state <= EX2;
            2'b00:   state <= IDLE;
            2'b10:   state <= WAIT_CLR;
            default: state <= EX1;
          endcase
        EX2:
          case (filt)
            2'b10:   state <= EX3;
            2'b01:   state <= EX1;
            2'b00:   state <= IDLE;
            default: state <= EX2;
          endcase
        EX3:
          case (filt)
            2'b00: begin
              state      <= IDLE;
              exit_pulse <= 1'b1;
            end
            2'b11:   state <= EX2;
            2'b01:   state <= WAIT_CLR;
            default: state <= EX3;
          endcase
        WAIT_CLR:
          if (filt == 2'b00) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_counter.sv
// Top-level occupancy block: merges per-lane events into a clamped count and drives
// full/empty flags plus a multiplexed active-low 7-segment display.
module parking_lot_counter
  import parking_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int CAPACITY    = 99,
  parameter int DIGITS      = 2,
  parameter int DEBOUNCE    = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int CW          = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 btnC,
  input  logic [NUM_LANES-1:0] S1,
  input  logic [NUM_LANES-1:0] S2,
  output logic [6:0]           seg,
  output logic [7:0]           an,
  output logic [NUM_LANES-1:0] entering,
  output logic [NUM_LANES-1:0] exiting,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty
);

  localparam int SW = CW + 4;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fsm #(.DEBOUNCE(DEBOUNCE)) u_lane (
      .clk        (clk),
      .btnC       (btnC),
      .s1_raw     (S1[i]),
      .s2_raw     (S2[i]),
      .enter_pulse(entering[i]),
      .exit_pulse (exiting[i])
    );
  end

  logic signed [SW-1:0] n_ent;
  logic signed [SW-1:0] n_ext;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] next_sum;

  // Simultaneous events net out before clamping, so a full lot with 2 in / 1 out stays full.
  always_comb begin
    n_ent = '0;
    n_ext = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_ent = n_ent + SW'(entering[i]);
      n_ext = n_ext + SW'(exiting[i]);
    end
    delta    = n_ent - n_ext;
    next_sum = $signed({4'b0000, count}) + delta;
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      count <= '0;
    end else if (next_sum[SW-1]) begin
      count <= '0;
    end else if (next_sum > CAP_S) begin
      count <= CW'(CAPACITY);
    end else begin
      count <= next_sum[CW-1:0];
    end
  end

  assign full  = (count == CW'(CAPACITY));
  assign empty = (count == '0);

  logic [RW-1:0] refresh_cnt;
  logic [2:0]    digit_idx;
  logic [31:0]   bcd;
  logic [3:0]    digit;

  always_ff @(posedge clk) begin
    if (btnC) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == 3'(DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_comb begin
    bcd            = bin2bcd(32'(count));
    digit          = bcd[{digit_idx, 2'b00} +: 4];
    seg            = seg_decode(digit);
    an             = 8'hFF;
    an[digit_idx]  = 1'b0;
  end

endmodule

// File: doc/parking_lot_counter.md
Name: parking_lot_counter

Overview:
Parametrised successor of the single-lane vehicle counter. It supports NUM_LANES independent sensor pairs (S1 outer, S2 inner), debounces each sensor, and runs one direction FSM per lane. Lane events merge into one occupancy count, clamped to [0, CAPACITY]. The block drives full/empty flags and a multiplexed active-low 7-segment display of DIGITS BCD digits. It is the top-level occupancy block on the board.

Parameters:
NUM_LANES, 2, number of entry/exit lanes (1..8)
CAPACITY, 99, maximum occupancy; count saturates here (must be < 10**DIGITS)
DIGITS, 2, displayed decimal digits (1..8)
DEBOUNCE, 4, consecutive stable synchronised cycles required before a sensor change is accepted
REFRESH_DIV, 1000, clk cycles per display digit slot
CW, $clog2(CAPACITY+1), count width (derived)

Ports:
clk  in  1  system clock, all logic on rising edge
btnC  in  1  synchronous active-high reset
S1  in  NUM_LANES  outer sensor per lane, raw, asynchronous
S2  in  NUM_LANES  inner sensor per lane, raw, asynchronous
seg  out  7  segments {g..a}, active-low
an  out  8  digit anodes, active-low; an[7:DIGITS] held 1
entering  out  NUM_LANES  1-cycle pulse per completed entry
exiting  out  NUM_LANES  1-cycle pulse per completed exit
count  out  CW  current occupancy
full  out  1  count == CAPACITY
empty  out  1  count == 0

Behaviour:
- Reset (btnC=1 at a clk edge), regardless of state or in-flight sequences:
  - all lane FSMs go to IDLE; synchronisers and debounce counters clear (filtered sensors 0).
  - count=0, entering=0, exiting=0, full=0, empty=1.
  - digit index=0, an=8'hFE, seg=7'b1000000.
- Input conditioning, per sensor:
  - 2-flop synchroniser, then a debounce counter.
  - The filtered value updates only after the synchronised value differs from it for DEBOUNCE consecutive cycles. Any glitch shorter than that resets the counter.
- Lane FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR. Inputs are the filtered pair {S1,S2}.
  - IDLE: 10->EN1; 01->EX1; 11->WAIT_CLR (simultaneous, direction unknown); 00 stays.
  - EN1: 11->EN2; 00->IDLE (backed out); 01->WAIT_CLR.
  - EN2: 01->EN3; 10->EN1; 00->WAIT_CLR is not possible, so 00->IDLE with no event.
  - EN3: 00->IDLE and entering[i]=1 for that one cycle; 11->EN2; 10->WAIT_CLR.
  - EX1/EX2/EX3 mirror EN1/EN2/EN3 with S1 and S2 swapped. The final 00 from EX3 pulses exiting[i].
  - WAIT_CLR: stays until 00, then IDLE. No event.
- Latency: entering/exiting pulses are registered and assert on the edge after the filtered sensors reach 00. Raw release to pulse is 2+DEBOUNCE+1 cycles. count updates on the following edge.
- Count update, one register:
  - delta = popcount(entering) - popcount(exiting), computed signed at CW+4 bits.
  - next = clamp(count+delta, 0, CAPACITY).
  - Simultaneous events net out first, then the result is clamped. Example: count=CAPACITY, 2 enters, 1 exit -> CAPACITY.
  - Pulses still fire when clamped.
- full and empty are combinational from count.
- Display:
  - Binary-to-BCD of count, combinational double-dabble.
  - A refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0..DIGITS-1 and then back to 0.
  - an[idx]=0, all other bits 1. seg is the decoded BCD digit idx: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, others=1111111.
  - Leading zeros are shown, not blanked.

Decomposition:
- Package parking_pkg holds:
  - typedef enum logic [2:0] lane_state_t, covering the 8 FSM states.
  - the 7-segment constant table (SEG_0..SEG_9, SEG_OFF).
  - the function bin2bcd.
- Sub-module lane_fsm, one instance per lane via generate:
  - contains the synchronisers, debouncers and FSM.
  - ports: clk, btnC, s1_raw, s2_raw, enter_pulse, exit_pulse.
  - exposes state for bench monitoring.
- The top level holds the count register, BCD conversion and display mux.

Test Plan:
1. Reset, then lane 0 runs S1, then S1+S2, then S2, then none (each phase held 20 cycles, DEBOUNCE=4) -> a single entering[0] pulse; count=1, empty=0; within 2*REFRESH_DIV cycles, the an=FE slot shows seg=1111001 and the an=FD slot shows seg=1000000.
2. Lanes 0 and 1 complete an entry on the same cycle, count=5 -> count=7 next cycle. Lane 0 entry and lane 1 exit on the same cycle -> count unchanged, both pulses seen.
3. Count=0, exit sequence on lane 1 -> exiting[1] pulses, count stays 0, empty=1. 100 entries with CAPACITY=99 -> count=99, full=1, display 9/9.
4. Invalid or aborted sequences -> no pulses, count unchanged, FSM back in IDLE. Cases: S1 and S2 rise together; S1 then release (back-out); S2-first sequence reversed mid-way; 2-cycle glitch on S1.
5. Reset asserted while lane 0 is in EN2 -> FSM IDLE, count=0; releasing the sensors afterwards produces no entering pulse.
6. Parameter sweep: NUM_LANES=4, DIGITS=3, CAPACITY=250, then 250 entries spread over the lanes -> count=250, full=1, an[2:0] cycling, an[7:3]=1, digits display 2/5/0.
